// File: rtl/writeback_encoder_16_4.sv
// Round-robin write-request encoder: 16 pending registers -> one 4-bit write ID per cycle.
// Optional WB_R0_WRITE_EN lets register 0 be written; by default R0 is hardwired zero.
module writeback_encoder_16_4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] set_req,
    input  logic        wr_ready,
    output logic        WriteEn,
    output logic [3:0]  WriteReg,
    output logic [15:0] pending,
    output logic        busy,
    output logic        dup_err
);

    logic [3:0]  last_id;
    logic [15:0] set_masked;
    logic [15:0] grant_onehot;
    logic [15:0] pending_next;
    logic        load;
    logic        found;
    logic [3:0]  winner;
    logic [3:0]  idx;

`ifdef WB_R0_WRITE_EN
    assign set_masked = set_req;
`else
    assign set_masked = {set_req[15:1], 1'b0};
`endif

    assign load = !WriteEn || wr_ready;

    // Scan starts one past the previous winner and wraps through all 16 slots.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            idx = last_id + 4'(k) + 4'd1;
            if (!found && pending[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (load && found) begin
            grant_onehot[winner] = 1'b1;
        end
    end

    // A set landing on the bit being granted re-arms it rather than flagging a duplicate.
    assign pending_next = (pending & ~grant_onehot) | set_masked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            WriteEn  <= 1'b0;
            WriteReg <= '0;
            last_id  <= 4'd15;
            dup_err  <= 1'b0;
        end else begin
            pending <= pending_next;
            if ((set_masked & pending & ~grant_onehot) != '0) begin
                dup_err <= 1'b1;
            end
            if (load) begin
                if (found) begin
                    WriteEn  <= 1'b1;
                    WriteReg <= winner;
                    last_id  <= winner;
                end else begin
                    WriteEn  <= 1'b0;
                end
            end
        end
    end

    assign busy = WriteEn | (|pending);

endmodule

// File: tb/tb_writeback_encoder_16_4.sv
// Self-checking bench for writeback_encoder_16_4 against a cycle-level behavioural model.
module tb_writeback_encoder_16_4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] set_req = '0;
    logic        wr_ready = 1'b0;
    logic        WriteEn;
    logic [3:0]  WriteReg;
    logic [15:0] pending;
    logic        busy;
    logic        dup_err;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state
    bit [15:0] m_pend;
    bit        m_en;
    bit [3:0]  m_reg;
    int        m_last;
    bit        m_dup;

    writeback_encoder_16_4 dut (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .wr_ready(wr_ready),
        .WriteEn(WriteEn), .WriteReg(WriteReg), .pending(pending),
        .busy(busy), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pend = '0; m_en = 0; m_reg = '0; m_last = 15; m_dup = 0;
    endfunction

    function automatic logic [22:0] model_vec();
        return {m_en, m_reg, m_pend, m_en | (|m_pend), m_dup};
    endfunction

    function automatic logic [22:0] dut_vec();
        return {WriteEn, WriteReg, pending, busy, dup_err};
    endfunction

    // Drive one cycle of inputs, advance the model by one edge, settle 1 time unit past it.
    task automatic step(input logic [15:0] s, input logic r);
        bit [15:0] sm, g;
        bit found;
        int w;
        set_req  = s;
        wr_ready = r;
        @(posedge clk);
        sm = s;
`ifndef WB_R0_WRITE_EN
        sm[0] = 1'b0;
`endif
        g = '0;
        if (!m_en || r) begin
            found = 0;
            w = 0;
            for (int k = 1; k <= 16; k++) begin
                if (!found && m_pend[(m_last + k) % 16]) begin
                    found = 1;
                    w = (m_last + k) % 16;
                end
            end
            if (found) begin
                m_en = 1; m_reg = 4'(w); m_last = w; g[w] = 1'b1;
            end else begin
                m_en = 0;
            end
        end
        if ((sm & m_pend & ~g) != 0) m_dup = 1;
        m_pend = (m_pend & ~g) | sm;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; set_req = '0; wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (dut_vec() !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 000000", dut_vec());
        end
    endtask

    task automatic test_single();
        apply_reset();
        step(16'h0008, 1'b1);
        n_checks++;
        if ({WriteEn, pending} !== {1'b0, 16'h0008}) begin
            n_fail++; $display("FAIL single_pend: got en=%b pend=%h want en=0 pend=0008", WriteEn, pending);
        end
        step(16'h0000, 1'b1);
        n_checks++;
        if ({WriteEn, WriteReg} !== {1'b1, 4'd3}) begin
            n_fail++; $display("FAIL single_grant: got en=%b reg=%0d want en=1 reg=3", WriteEn, WriteReg);
        end
        step(16'h0000, 1'b1);
        n_checks++;
        if ({WriteEn, pending, busy} !== {1'b0, 16'h0000, 1'b0}) begin
            n_fail++; $display("FAIL single_idle: got en=%b pend=%h busy=%b want 0/0000/0", WriteEn, pending, busy);
        end
    endtask

    task automatic test_multi();
        int got[$];
        int exp[$];
`ifdef WB_R0_WRITE_EN
        exp = '{0, 5, 10, 15};
`else
        exp = '{5, 10, 15};
`endif
        apply_reset();
        step(16'h8421, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(16'h0000, 1'b1);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL multi_model: got %h want %h", dut_vec(), model_vec());
            end
            if (WriteEn) got.push_back(int'(WriteReg));
        end
        n_checks++;
        if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL multi_count: got %0d grants want %0d", got.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                n_checks++;
                if (got[i] != exp[i]) begin
                    n_fail++; $display("FAIL multi_order[%0d]: got %0d want %0d", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        step(16'h4000, 1'b1);
        step(16'h0000, 1'b1);
        n_checks++;
        if ({WriteEn, WriteReg} !== {1'b1, 4'd14}) begin
            n_fail++; $display("FAIL wrap_14: got en=%b reg=%0d want 1/14", WriteEn, WriteReg);
        end
        step(16'h8004, 1'b1);
        step(16'h0000, 1'b1);
        n_checks++;
        if ({WriteEn, WriteReg} !== {1'b1, 4'd15}) begin
            n_fail++; $display("FAIL wrap_15: got en=%b reg=%0d want 1/15", WriteEn, WriteReg);
        end
        step(16'h0000, 1'b1);
        n_checks++;
        if ({WriteEn, WriteReg} !== {1'b1, 4'd2}) begin
            n_fail++; $display("FAIL wrap_2: got en=%b reg=%0d want 1/2", WriteEn, WriteReg);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        step(16'h0080, 1'b1);
        step(16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step((i == 0) ? 16'h0002 : 16'h0000, 1'b0);
            n_checks++;
            if ({WriteEn, WriteReg} !== {1'b1, 4'd7}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got en=%b reg=%0d want 1/7", i, WriteEn, WriteReg);
            end
        end
        step(16'h0000, 1'b1);
        n_checks++;
        if ({WriteEn, WriteReg} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL bp_next: got en=%b reg=%0d want 1/1", WriteEn, WriteReg);
        end
    endtask

    task automatic test_dup();
        apply_reset();
        step(16'h0080, 1'b1);
        step(16'h0000, 1'b0);
        step(16'h0010, 1'b0);
        n_checks++;
        if (dup_err !== 1'b0) begin
            n_fail++; $display("FAIL dup_first: got %b want 0", dup_err);
        end
        step(16'h0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dup_err !== 1'b1) begin
                n_fail++; $display("FAIL dup_sticky[%0d]: got %b want 1", i, dup_err);
            end
            step(16'h0000, 1'b1);
        end
        apply_reset();
        step(16'h0010, 1'b1);
        step(16'h0010, 1'b1);
        n_checks++;
        if ({WriteEn, WriteReg, pending, dup_err} !== {1'b1, 4'd4, 16'h0010, 1'b0}) begin
            n_fail++; $display("FAIL dup_setclr: got en=%b reg=%0d pend=%h dup=%b want 1/4/0010/0",
                               WriteEn, WriteReg, pending, dup_err);
        end
        step(16'h0000, 1'b1);
        n_checks++;
        if ({WriteEn, WriteReg, dup_err} !== {1'b1, 4'd4, 1'b0}) begin
            n_fail++; $display("FAIL dup_regrant: got en=%b reg=%0d dup=%b want 1/4/0", WriteEn, WriteReg, dup_err);
        end
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        step(16'h06E4, 1'b0);
        step(16'h0000, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec() !== 23'd0) begin
            n_fail++; $display("FAIL midreset_async: got %h want 000000", dut_vec());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(16'h0000, 1'b1);
            n_checks++;
            if (WriteEn !== 1'b0 || dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL midreset_quiet[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] s;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            s = '0;
            if ($urandom_range(0, 2) == 0) s = 16'($urandom) & 16'($urandom);
            step(s, 1'($urandom_range(0, 3) != 0));
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_multi();
        test_wrap();
        test_backpressure();
        test_dup();
        test_reset_midburst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
